// File: rtl/clic_irq_dispatch.sv
// Sequencer between the CLIC interrupt output and the core interrupt interface:
// holds an offer until accepted, preempts or retracts it via the kill handshake.
module clic_irq_dispatch #(
  parameter int unsigned SRC_W      = 8,
  parameter int unsigned LAT_W      = 16,
  parameter bit          PREEMPT_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [SRC_W-1:0] up_id_i,
  input  logic [7:0]       up_level_i,
  input  logic             up_shv_i,
  input  logic [1:0]       up_priv_i,
  input  logic             up_kill_req_i,
  output logic             up_kill_ack_o,
  output logic             irq_valid_o,
  input  logic             irq_ready_i,
  output logic [SRC_W-1:0] irq_id_o,
  output logic [7:0]       irq_level_o,
  output logic             irq_shv_o,
  output logic [1:0]       irq_priv_o,
  output logic             irq_kill_req_o,
  input  logic             irq_kill_ack_i,
  output logic [LAT_W-1:0] lat_o,
  output logic             lat_valid_o
);

  typedef enum logic [1:0] {IDLE, OFFER, KILL} state_t;
  typedef enum logic {RETRACT, PREEMPT} reason_t;

  state_t           state;
  reason_t          reason;
  logic [SRC_W-1:0] buf_id;
  logic [7:0]       buf_level;
  logic             buf_shv;
  logic [1:0]       buf_priv;
  logic             kill_pend;
  logic             ack_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_inc;
  logic             preempt;

  assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);

  assign preempt = PREEMPT_EN && up_valid_i &&
                   (up_level_i > buf_level) && (up_priv_i >= buf_priv);

  // The ack register suppresses back-to-back acks while the CLIC still holds its request.
  always_comb begin
    up_ready_o    = 1'b0;
    up_kill_ack_o = 1'b0;
    case (state)
      IDLE: begin
        up_ready_o    = up_valid_i;
        up_kill_ack_o = up_kill_req_i && !ack_q;
      end
      KILL: begin
        if (irq_kill_ack_i) begin
          up_kill_ack_o = kill_pend;
          up_ready_o    = (reason == PREEMPT) && up_valid_i;
        end
      end
      default: ;
    endcase
  end

  assign irq_id_o    = buf_id;
  assign irq_level_o = buf_level;
  assign irq_shv_o   = buf_shv;
  assign irq_priv_o  = buf_priv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      reason         <= RETRACT;
      buf_id         <= '0;
      buf_level      <= '0;
      buf_shv        <= 1'b0;
      buf_priv       <= '0;
      kill_pend      <= 1'b0;
      ack_q          <= 1'b0;
      lat_cnt        <= '0;
      lat_o          <= '0;
      lat_valid_o    <= 1'b0;
      irq_valid_o    <= 1'b0;
      irq_kill_req_o <= 1'b0;
    end else begin
      lat_valid_o <= 1'b0;
      ack_q       <= up_kill_ack_o;
      if (up_ready_o) begin
        buf_id    <= up_id_i;
        buf_level <= up_level_i;
        buf_shv   <= up_shv_i;
        buf_priv  <= up_priv_i;
        lat_cnt   <= '0;
      end
      case (state)
        IDLE: begin
          if (up_valid_i) begin
            state       <= OFFER;
            irq_valid_o <= 1'b1;
          end
        end
        OFFER: begin
          if (irq_ready_i) begin
            lat_o       <= lat_inc;
            lat_valid_o <= 1'b1;
            state       <= IDLE;
            irq_valid_o <= 1'b0;
          end else if (up_kill_req_i) begin
            kill_pend      <= 1'b1;
            reason         <= RETRACT;
            state          <= KILL;
            irq_valid_o    <= 1'b0;
            irq_kill_req_o <= 1'b1;
          end else if (preempt) begin
            reason         <= PREEMPT;
            state          <= KILL;
            irq_valid_o    <= 1'b0;
            irq_kill_req_o <= 1'b1;
          end else begin
            lat_cnt <= lat_inc;
          end
        end
        KILL: begin
          if (irq_kill_ack_i) begin
            kill_pend      <= 1'b0;
            irq_kill_req_o <= 1'b0;
            if (up_ready_o) begin
              state       <= OFFER;
              irq_valid_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (up_kill_req_i) begin
            kill_pend <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          irq_valid_o    <= 1'b0;
          irq_kill_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
